input_debouncer: RTL and testbench
==================================

# input_debouncer

Front-end conditioning stage for the lab board's raw switch and button inputs. It synchronizes the eight slide switches and the centre button into the `clock` domain, then debounces each channel with its own counter. It produces glitch-free levels plus single-cycle event pulses. Its `sw_clean` drives the operand inputs of the add/subtract display path, and `btn_clean` drives that path's reset.

## Interface

Parameters:
- `STABLE_CYCLES`, default 100000: consecutive synchronized cycles a channel must hold a new value before it is accepted; legal range 1 to 2^20; counter width is ceil(log2(STABLE_CYCLES+1)).

Ports:
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; sampled on the `clock` rising edge.
- `sw_raw`  input  8  asynchronous slide-switch levels.
- `btn_raw`  input  1  asynchronous centre-button level.
- `sw_clean`  output  8  debounced switch levels.
- `btn_clean`  output  1  debounced button level.
- `btn_press`  output  1  one-cycle pulse on a `btn_clean` 0->1 transition.
- `btn_release`  output  1  one-cycle pulse on a `btn_clean` 1->0 transition.
- `sw_changed`  output  1  one-cycle pulse when any `sw_clean` bit updates.

## Operation

- Nine independent channels: `sw_raw[7:0]` and `btn_raw`.
- Each channel passes through a 2-flop synchronizer (sync1 -> sync2).
- Each channel has a counter `cnt` and a registered output `clean`. On every rising edge with `reset` low:
  - If sync2 == clean: `cnt` <= 0.
  - If sync2 != clean and `cnt` == STABLE_CYCLES-1: `clean` <= sync2 and `cnt` <= 0.
  - Otherwise, when sync2 != clean: `cnt` <= `cnt`+1.
- Any return of sync2 to the current `clean` value before acceptance clears `cnt`. A bounce restarts the full count, and no partial credit is kept.
- Pulses are registered together with the `clean` update that causes them:
  - `btn_press` = button update to 1.
  - `btn_release` = button update to 0.
  - `sw_changed` = OR of the update strobes of all eight switch channels.
- Several switch bits accepted on the same edge produce one `sw_changed` pulse, not several. Switch and button channels never interact.
- `btn_press` and `btn_release` are never high together. Neither pulse stays high for more than one cycle.
- Reset behaviour:
  - On `reset`, all sync flops, counters, `sw_clean`, `btn_clean` and all pulse outputs go to 0 on that edge.
  - Reset mid-count discards the count; no output changes as a result of it.
  - After `reset` deasserts, an input already high is treated as a fresh change and needs the full latency.
- The block's own `reset` is the board power-on or system reset. It is never driven from `btn_clean`.

## Timing

- Edge numbering: the first rising edge at which sync1 samples a new, steady raw value is edge 1.
- sync2 holds the new value after edge 2, and `cnt` increments on edges 3 through STABLE_CYCLES+1.
- `clean` and the matching pulse update on edge STABLE_CYCLES+2, so latency from raw change to output is STABLE_CYCLES+2 cycles.
- The pulse is high for exactly the one cycle following edge STABLE_CYCLES+2.
- Minimum accepted stable duration is STABLE_CYCLES synchronized cycles. A raw pulse shorter than that is never reported.
- With `reset` high on an edge, every output is 0 for the cycle after that edge, regardless of input.
- Throughput: after an acceptance, the next opposite change on the same channel needs another full STABLE_CYCLES+2 cycles.
- No combinational path from any input to any output; all outputs come directly from flops.

## Test plan

All scenarios use STABLE_CYCLES=4 unless stated.

- **Reset:** hold `reset`=1 for 3 edges with `sw_raw`=8'hFF, `btn_raw`=1 -> all outputs 0 throughout and on the cycle after the last reset edge. Release reset with inputs held -> `sw_clean`=8'hFF, `btn_clean`=1, one `sw_changed` pulse and one `btn_press` pulse, all on edge 6.
- **Clean step:** `sw_raw` 8'h00->8'hA5, steady from edge 1 -> `sw_clean`=8'hA5 after edge 6. `sw_changed` is high for exactly that one cycle, and `btn_*` stay 0.
- **Bounce:** after reset, with `btn_clean`=0:
  - `btn_raw` sampled as 1,1,1,0, then 1 steady -> `btn_clean` rises only 6 edges after the final 0->1.
  - Exactly one `btn_press` pulse, and zero `btn_release` pulses.
- **Release and mutual exclusion:** from `btn_clean`=1, set `btn_raw`=0 steady -> one `btn_release` pulse on edge 6. `btn_press` stays 0, and the pulse never spans two cycles.
- **Glitch rejection:** `sw_raw[7]` high for 3 edges, then low -> `sw_clean` unchanged and no `sw_changed` pulse. Repeat with STABLE_CYCLES=1 and a 1-edge pulse -> accepted on edge 3 and then reverted on edge 4, with two `sw_changed` pulses.
- **Reset mid-count:** `sw_raw`=8'h0F from edge 1, `reset` asserted on edge 4 only -> `sw_clean` stays 8'h00 with no pulse. With `sw_raw` still 8'h0F, `sw_clean`=8'h0F on the 6th edge after reset deasserts.

Source files
------------

// File: rtl/input_debouncer.sv
// Two-flop synchronizer and per-channel stability counter for eight slide
// switches and one button, with registered level and single-cycle event outputs.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] sw_raw,
  input  logic       btn_raw,
  output logic [7:0] sw_clean,
  output logic       btn_clean,
  output logic       btn_press,
  output logic       btn_release,
  output logic       sw_changed
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  // Channel 8 is the button, channels 7:0 the switches.
  logic [8:0]    raw;
  logic [8:0]    sync1;
  logic [8:0]    sync2;
  logic [8:0]    clean;
  logic [8:0]    upd;
  logic [CW-1:0] cnt [9];

  assign raw = {btn_raw, sw_raw};

  always_comb begin
    upd = '0;
    for (int i = 0; i < 9; i++) begin
      upd[i] = (sync2[i] != clean[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      clean       <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      sw_changed  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 9; i++) begin
        // Any return to the accepted level drops all accumulated credit.
        if ((sync2[i] == clean[i]) || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
        if (upd[i]) begin
          clean[i] <= sync2[i];
        end
      end
      btn_press   <= upd[8] & sync2[8];
      btn_release <= upd[8] & ~sync2[8];
      sw_changed  <= |upd[7:0];
    end
  end

  assign sw_clean  = clean[7:0];
  assign btn_clean = clean[8];

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench: stimulus queues expected pulse events, negedge monitors
// pop and compare them whenever a debouncer presents a pulse.
module tb_input_debouncer;

  typedef struct packed {
    int         cyc;
    logic [7:0] sw;
    logic       btn;
    logic       press;
    logic       rel;
    logic       chg;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_a = '0;
  logic       btn_a = 1'b0;
  logic [7:0] sw_b = '0;
  logic       btn_b = 1'b0;

  logic [7:0] swc_a, swc_b;
  logic       btnc_a, prs_a, rel_a, chg_a;
  logic       btnc_b, prs_b, rel_b, chg_b;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  ev_t q_a[$];
  ev_t q_b[$];

  input_debouncer #(.STABLE_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset),
    .sw_raw(sw_a), .btn_raw(btn_a),
    .sw_clean(swc_a), .btn_clean(btnc_a),
    .btn_press(prs_a), .btn_release(rel_a),
    .sw_changed(chg_a)
  );

  input_debouncer #(.STABLE_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset),
    .sw_raw(sw_b), .btn_raw(btn_b),
    .sw_clean(swc_b), .btn_clean(btnc_b),
    .btn_press(prs_b), .btn_release(rel_b),
    .sw_changed(chg_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic ev_t mk(input int c, input logic [7:0] s, input logic b,
                             input logic p, input logic r, input logic ch);
    ev_t e;
    e.cyc = c; e.sw = s; e.btn = b; e.press = p; e.rel = r; e.chg = ch;
    return e;
  endfunction

  always @(negedge clock) begin
    if (chg_a | prs_a | rel_a) begin
      ev_t act;
      act = mk(cyc, swc_a, btnc_a, prs_a, rel_a, chg_a);
      n_chk++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse_a: got %h expected none", act);
      end else begin
        ev_t exp;
        exp = q_a.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL event_a: got %h expected %h", act, exp);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chg_b | prs_b | rel_b) begin
      ev_t act;
      act = mk(cyc, swc_b, btnc_b, prs_b, rel_b, chg_b);
      n_chk++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse_b: got %h expected none", act);
      end else begin
        ev_t exp;
        exp = q_b.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL event_b: got %h expected %h", act, exp);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    check(name, {19'd0, swc_a, btnc_a, prs_a, rel_a, chg_a}, 32'd0);
    check(name, {19'd0, swc_b, btnc_b, prs_b, rel_b, chg_b}, 32'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    sw_a = '0; btn_a = 1'b0; sw_b = '0; btn_b = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(3);
  endtask

  initial begin
    // Reset held three edges with all inputs high
    sw_a = 8'hFF; btn_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_zero("reset_hold");
    end
    reset = 1'b0;
    q_a.push_back(mk(cyc + 6, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1));
    tick(5);
    check("post_reset_edge5_sw", {24'd0, swc_a}, 32'h00);
    check("post_reset_edge5_btn", {31'd0, btnc_a}, 32'd0);
    tick(1);
    check("post_reset_edge6_sw", {24'd0, swc_a}, 32'hFF);
    check("post_reset_edge6_btn", {31'd0, btnc_a}, 32'd1);
    tick(3);

    // Clean step 00 -> A5
    do_reset();
    sw_a = 8'hA5;
    q_a.push_back(mk(cyc + 6, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(8);
    check("step_sw", {24'd0, swc_a}, 32'hA5);

    // Bounce: 1,1,1,0 then steady 1
    btn_a = 1'b1;
    tick(3);
    btn_a = 1'b0;
    tick(1);
    btn_a = 1'b1;
    q_a.push_back(mk(cyc + 6, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(5);
    check("bounce_edge5_btn", {31'd0, btnc_a}, 32'd0);
    tick(3);
    check("bounce_btn", {31'd0, btnc_a}, 32'd1);

    // Release
    btn_a = 1'b0;
    q_a.push_back(mk(cyc + 6, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(8);
    check("release_btn", {31'd0, btnc_a}, 32'd0);

    // Glitch rejection, 3-edge pulse with STABLE_CYCLES=4
    do_reset();
    sw_a[7] = 1'b1;
    tick(3);
    sw_a[7] = 1'b0;
    tick(10);
    check("glitch_a_sw", {24'd0, swc_a}, 32'h00);

    // 1-edge pulse with STABLE_CYCLES=1 is accepted then reverted
    sw_b[7] = 1'b1;
    q_b.push_back(mk(cyc + 3, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1));
    q_b.push_back(mk(cyc + 4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(1);
    sw_b[7] = 1'b0;
    tick(6);
    check("glitch_b_sw", {24'd0, swc_b}, 32'h00);

    // Reset on edge 4 of a pending change
    sw_a = 8'h0F;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_zero("mid_reset");
    q_a.push_back(mk(cyc + 6, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(5);
    check("mid_reset_edge5_sw", {24'd0, swc_a}, 32'h00);
    tick(1);
    check("mid_reset_edge6_sw", {24'd0, swc_a}, 32'h0F);
    tick(4);

    check("queue_a_drained", q_a.size(), 32'd0);
    check("queue_b_drained", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
